wb_b3_burst_master: RTL and testbench
=====================================

// Module: wb_b3_burst_master
// PURPOSE
//  Wishbone B3 initiator: turns one command (address, length, direction, BTE) into
//  a classic or incrementing/wrapping burst on a 32-bit bus. Counterpart of the
//  ram_wb_b3 responder; used as a bench/DMA master on the shared intercon.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width; byte lanes = DW/8
//  MAX_RTY  3    retries of a beat after wbm_rty_i before aborting with error
//  TIMEOUT  255  stalled-beat cycles before abort (WB_B3_MASTER_TIMEOUT_EN only)
// PORTS
//  wb_clk_i     in   1     clock
//  wb_rst_i     in   1     reset: asynchronous, active-high
//  cmd_valid_i  in   1     command request
//  cmd_ready_o  out  1     high in IDLE; command taken when valid&ready
//  cmd_adr_i    in   AW    start byte address, low 2 bits ignored (forced 0)
//  cmd_we_i     in   1     1 = write burst, 0 = read burst
//  cmd_len_i    in   5     beats 1..16; 0 is treated as 1
//  cmd_bte_i    in   2     00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wr_dat_i     in   DW    current write beat (driven straight to wbm_dat_o)
//  wr_sel_i     in   DW/8  current write byte enables
//  wr_ack_o     out  1     pulse: current write beat accepted; present next beat
//  rd_dat_o     out  DW    registered read data
//  rd_vld_o     out  1     pulse: rd_dat_o holds a new beat
//  done_o       out  1     pulse: command finished (ok or error)
//  err_o        out  1     qualifies done_o: command aborted
//  wbm_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o[2:0]/bte_o[1:0]  out  bus master
//  wbm_dat_i/ack_i/err_i/rty_i                                 in   bus responses
// BEHAVIOUR
//  Reset: state IDLE; cyc,stb,we,rd_vld,wr_ack,done,err = 0; adr,dat,sel,rd_dat = 0;
//   cti = 000, bte = 00. Reset mid-burst drops cyc/stb asynchronously; no done_o.
//  FSM IDLE -> BUS on cmd accept; cyc,stb rise the next cycle (1-cycle latency).
//   BUS: one beat per cycle with ack; stb held high between beats (no wait states
//   inserted by master). Last beat acked -> DONE. DONE: done_o=1 one cycle -> IDLE.
//   rty on a beat -> RTY: cyc,stb low one cycle, then BUS reissues the same beat
//   (same adr, cti). More than MAX_RTY consecutive rty on one beat -> DONE, err_o=1.
//   err on any beat -> DONE with err_o=1; remaining beats not issued.
//  ack/err/rty only honoured while stb=1; priority err > rty > ack if simultaneous.
//  CTI: len==1 -> 000 classic. len>1 -> 010 on every beat except last -> 111.
//  bte_o = cmd_bte for len>1, 00 for classic.
//  Address: beat n adr = base + 4n for linear; wrapN: upper bits fixed, low
//   log2(N)+2 bits = (base low + 4n) mod 4N. Adr advances only on ack.
//  Reads: rd_dat_o <= wbm_dat_i, rd_vld_o=1 in the cycle after each read ack.
//  Writes: wbm_we_o=1 whole burst; wr_ack_o = wbm_ack_i & stb & we (same cycle).
//  Beat counter 5 bits, counts down from len; last beat when counter==1.
//  cmd_valid_i ignored outside IDLE; command fields latched at accept.
// CONFIGURATION
//  WB_B3_MASTER_TIMEOUT_EN defined: 8-bit counter, cleared on any response or
//   new beat, counts while stb high; reaching TIMEOUT drops cyc/stb -> DONE, err_o=1.
//  Not defined: no counter; master waits indefinitely for a response.
// TESTING
//  1 read len=1 adr=0x100, ack after 2 wait cycles -> cti=000, rd_vld once, done, err=0
//  2 write len=4 linear adr=0x200 -> adr 0x200..0x20C, cti 010,010,010,111, 4 wr_ack
//  3 read len=8 wrap8 adr=0x118 -> adr 0x118,11C,100,104,108,10C,110,114, bte=10
//  4 rty on beat 2 of len=4 twice then ack -> beat 2 reissued at same adr, 4 beats total,
//    err=0; rty 4x on one beat -> done_o with err_o=1, cyc low
//  5 err on beat 3 of len=16 -> no further stb, done_o+err_o same cycle, back to IDLE
//  6 TIMEOUT_EN, no response -> cyc drops after 255 cycles, err_o=1; reset mid-burst ->
//    cyc=0 immediately, cmd_ready_o=1 after reset release

Source files
------------

// File: rtl/wb_b3_burst_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : wb_b3_burst_master                                       |
// | Description : Wishbone B3 initiator. Turns one command (address,       |
// |               length, direction, BTE) into a classic or incrementing/  |
// |               wrapping burst with retry, error and optional timeout    |
// |               abort. Optional feature macro: WB_B3_MASTER_TIMEOUT_EN   |
// |               (stalled-beat timeout counter).                          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module wb_b3_burst_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_RTY = 3,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic            cmd_we_i,
  input  logic [4:0]      cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic [DW-1:0]   wr_dat_i,
  input  logic [DW/8-1:0] wr_sel_i,
  output logic            wr_ack_o,
  output logic [DW-1:0]   rd_dat_o,
  output logic            rd_vld_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i
);

  localparam int c_RW = $clog2(MAX_RTY + 2);
`ifdef WB_B3_MASTER_TIMEOUT_EN
  localparam bit c_TMO_EN = 1'b1;
`else
  localparam bit c_TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RTY  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            burst_q, burst_d;
  logic [1:0]      bte_q, bte_d;
  logic [c_RW-1:0] rty_q, rty_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rd_dat_q;
  logic            rd_vld_q;

  logic            w_stb, w_err, w_rty, w_ack, w_last, w_any_resp, w_tmo_hit;
  logic [AW-1:0]   w_wrap_mask, w_adr_next;

  // Only responses seen while strobing count; err beats rty beats ack
  assign w_stb      = (state_q == S_BUS);
  assign w_any_resp = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign w_err      = w_stb & wbm_err_i;
  assign w_rty      = w_stb & wbm_rty_i & ~wbm_err_i;
  assign w_ack      = w_stb & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
  assign w_last     = (cnt_q == 5'd1);

  // Wrapping bursts only advance the low log2(N)+2 address bits
  always_comb begin
    w_wrap_mask = '1;
    case (bte_q)
      2'b01:   w_wrap_mask = AW'(6'h0F);
      2'b10:   w_wrap_mask = AW'(6'h1F);
      2'b11:   w_wrap_mask = AW'(6'h3F);
      default: w_wrap_mask = '1;
    endcase
    w_adr_next = (adr_q & ~w_wrap_mask) | ((adr_q + AW'(4)) & w_wrap_mask);
  end

  generate
    if (c_TMO_EN) begin : g_tmo
      logic [7:0] tmo_q;
      assign w_tmo_hit = w_stb & ~w_any_resp & (tmo_q == 8'(TIMEOUT - 1));
      // Count stalled strobe cycles; any response or a fresh beat restarts it
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                  tmo_q <= 8'd0;
        else if (w_stb && !w_any_resp) tmo_q <= tmo_q + 8'd1;
        else                           tmo_q <= 8'd0;
      end
    end else begin : g_no_tmo
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  // State and command registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      cnt_q   <= 5'd0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      bte_q   <= 2'b00;
      rty_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      bte_q   <= bte_d;
      rty_q   <= rty_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, beat sequencing, retry and abort
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    burst_d = burst_q;
    bte_d   = bte_q;
    rty_d   = rty_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_BUS;
          adr_d   = cmd_adr_i & ~AW'(3);
          cnt_d   = (cmd_len_i == 5'd0) ? 5'd1 : cmd_len_i;
          we_d    = cmd_we_i;
          burst_d = (cmd_len_i > 5'd1);
          bte_d   = (cmd_len_i > 5'd1) ? cmd_bte_i : 2'b00;
          rty_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_BUS: begin
        if (w_err) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (w_rty) begin
          if (rty_q == c_RW'(MAX_RTY)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_RTY;
            rty_d   = rty_q + c_RW'(1);
          end
        end else if (w_ack) begin
          rty_d = '0;
          if (w_last) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
            adr_d = w_adr_next;
          end
        end else if (w_tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RTY:   state_d = S_BUS;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data capture, valid one cycle after each read ack
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= w_ack & ~we_q;
      if (w_ack && !we_q) rd_dat_q <= wbm_dat_i;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign wbm_cyc_o   = w_stb;
  assign wbm_stb_o   = w_stb;
  assign wbm_adr_o   = adr_q;
  assign wbm_we_o    = we_q & ((state_q == S_BUS) | (state_q == S_RTY));
  assign wbm_dat_o   = wbm_we_o ? wr_dat_i : '0;
  assign wbm_sel_o   = wbm_we_o ? wr_sel_i : '0;
  assign wbm_cti_o   = (!w_stb || !burst_q) ? 3'b000 : (w_last ? 3'b111 : 3'b010);
  assign wbm_bte_o   = w_stb ? bte_q : 2'b00;
  assign wr_ack_o    = w_ack & we_q;
  assign rd_dat_o    = rd_dat_q;
  assign rd_vld_o    = rd_vld_q;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_DONE) & err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_b3_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : tb_wb_b3_burst_master                                    |
// | Description : Scoreboard bench for wb_b3_burst_master with a scripted  |
// |               Wishbone responder (wait states, retry, error).          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_wb_b3_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [4:0]  cmd_len_i;
  logic [1:0]  cmd_bte_i;
  logic [31:0] wr_dat_i, rd_dat_o, wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wr_sel_i, wbm_sel_o;
  logic        wr_ack_o, rd_vld_o, done_o, err_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  always #5 clk = ~clk;

  wb_b3_burst_master dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
    .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
    .wr_dat_i(wr_dat_i), .wr_sel_i(wr_sel_i), .wr_ack_o(wr_ack_o),
    .rd_dat_o(rd_dat_o), .rd_vld_o(rd_vld_o), .done_o(done_o), .err_o(err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] rd_q[$];
  beat_t       e;

  int n_checks = 0, n_pass = 0;
  int cfg_wait = 0, cfg_rty_beat = -1, cfg_rty_n = 0, cfg_err_beat = -1;
  int beat_idx = 0, rty_seen = 0, wait_cnt = 0, wbeat = 0;
  bit wr_pending = 1'b0, post_rty = 1'b0;
  int rd_vld_cnt = 0, done_cnt = 0;
  logic last_err = 1'b0, done_cyc = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_adr(input logic [31:0] base, input logic [1:0] bte,
                                          input int n, input int len);
    logic [31:0] b, m;
    b = base & ~32'h3;
    if (len <= 1 || bte == 2'b00) return b + 32'(4 * n);
    m = (bte == 2'b01) ? 32'h0F : (bte == 2'b10) ? 32'h1F : 32'h3F;
    return (b & ~m) | ((b + 32'(4 * n)) & m);
  endfunction

  function automatic logic [3:0] sel_of(input int n);
    return (n % 2 == 1) ? 4'h3 : 4'hF;
  endfunction

  // Responder: wait states, scripted rty/err, checks each beat against the scoreboard
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    wbm_dat_i = 32'hDEADBEEF;
    wr_dat_i  = 32'hA5000000; wr_sel_i = 4'hF;
    forever begin
      @(negedge clk);
      if (wr_pending) begin wbeat++; wr_pending = 1'b0; end
      wr_dat_i  = 32'hA5000000 | 32'(wbeat);
      wr_sel_i  = sel_of(wbeat);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
      wbm_dat_i = 32'hDEADBEEF;
      #1;
      if (post_rty) begin
        check_eq("cyc_low_after_rty", 32'(wbm_cyc_o), 32'd0);
        post_rty = 1'b0;
      end
      if (wbm_stb_o && !rst) begin
        if (wait_cnt < cfg_wait) wait_cnt++;
        else begin
          wait_cnt = 0;
          check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            check_eq("adr", wbm_adr_o, e.adr);
            check_eq("cti", 32'(wbm_cti_o), 32'(e.cti));
            check_eq("bte", 32'(wbm_bte_o), 32'(e.bte));
            check_eq("we", 32'(wbm_we_o), 32'(e.we));
            if (beat_idx == cfg_err_beat) wbm_err_i = 1'b1;
            else if (beat_idx == cfg_rty_beat && rty_seen < cfg_rty_n) begin
              wbm_rty_i = 1'b1; rty_seen++; post_rty = 1'b1;
            end else begin
              wbm_ack_i = 1'b1;
              void'(exp_q.pop_front());
              beat_idx++;
              if (e.we) begin
                check_eq("wr_dat", wbm_dat_o, e.dat);
                check_eq("wr_sel", 32'(wbm_sel_o), 32'(e.sel));
                wr_pending = 1'b1;
              end else begin
                wbm_dat_i = {16'hD17A, e.adr[15:0]};
                rd_q.push_back(wbm_dat_i);
              end
              #1;
              check_eq("wr_ack", 32'(wr_ack_o), 32'(e.we));
            end
          end
        end
      end
    end
  end

  // Output monitor: read data scoreboard and completion capture
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rd_vld_o) begin
        rd_vld_cnt++;
        check_eq("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) check_eq("rd_dat", rd_dat_o, rd_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        last_err = err_o;
        done_cyc = wbm_cyc_o;
      end
    end
  end

  task automatic run_cmd(input logic [31:0] adr, input logic we, input int len,
                         input logic [1:0] bte, input int wt, input int rb, input int rn,
                         input int eb, input logic exp_err, input int exp_acked);
    int eff, d0, t;
    beat_t b;
    eff = (len == 0) ? 1 : len;
    cfg_wait = wt; cfg_rty_beat = rb; cfg_rty_n = rn; cfg_err_beat = eb;
    beat_idx = 0; rty_seen = 0; wait_cnt = 0; wbeat = 0; wr_pending = 1'b0;
    exp_q.delete();
    for (int n = 0; n < eff; n++) begin
      b.adr = exp_adr(adr, bte, n, eff);
      b.cti = (eff == 1) ? 3'b000 : (n == eff - 1) ? 3'b111 : 3'b010;
      b.bte = (eff == 1) ? 2'b00 : bte;
      b.we  = we;
      b.dat = 32'hA5000000 | 32'(n);
      b.sel = sel_of(n);
      exp_q.push_back(b);
    end
    d0 = done_cnt;
    @(negedge clk);
    check_eq("cmd_ready", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_adr_i = adr; cmd_we_i = we;
    cmd_len_i = 5'(len); cmd_bte_i = bte;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    #1 check_eq("cyc_rise", 32'(wbm_cyc_o), 32'd1);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin @(negedge clk); #3; t++; end
    check_eq("done_seen", 32'(done_cnt - d0), 32'd1);
    check_eq("err", 32'(last_err), 32'(exp_err));
    check_eq("cyc_at_done", 32'(done_cyc), 32'd0);
    check_eq("beats_acked", 32'(beat_idx), 32'(exp_acked));
    @(negedge clk); #3;
    check_eq("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check_eq("idle_ready", 32'(cmd_ready_o), 32'd1);
    exp_q.delete(); rd_q.delete();
    cfg_wait = 0; cfg_rty_beat = -1; cfg_rty_n = 0; cfg_err_beat = -1;
  endtask

  initial begin
    int v0, d0, t;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_we_i = 1'b0;
    cmd_len_i = '0; cmd_bte_i = '0;
    #12;
    check_eq("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(wbm_stb_o), 32'd0);
    check_eq("rst_we", 32'(wbm_we_o), 32'd0);
    check_eq("rst_adr", wbm_adr_o, 32'd0);
    check_eq("rst_dat", wbm_dat_o, 32'd0);
    check_eq("rst_cti", 32'(wbm_cti_o), 32'd0);
    check_eq("rst_bte", 32'(wbm_bte_o), 32'd0);
    check_eq("rst_outs", {rd_dat_o[27:0], rd_vld_o, done_o, err_o, wr_ack_o}, 32'd0);
    check_eq("rst_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk); rst = 1'b0;

    // classic read with two wait states
    v0 = rd_vld_cnt;
    run_cmd(32'h100, 1'b0, 1, 2'b00, 2, -1, 0, -1, 1'b0, 1);
    check_eq("rd_vld_once", 32'(rd_vld_cnt - v0), 32'd1);
    // linear write burst
    run_cmd(32'h200, 1'b1, 4, 2'b00, 0, -1, 0, -1, 1'b0, 4);
    // wrap8 read
    run_cmd(32'h118, 1'b0, 8, 2'b10, 0, -1, 0, -1, 1'b0, 8);
    // wrap4 and wrap16 over longer runs, with wait states
    run_cmd(32'h108, 1'b0, 6, 2'b01, 1, -1, 0, -1, 1'b0, 6);
    run_cmd(32'h13C, 1'b1, 16, 2'b11, 0, -1, 0, -1, 1'b0, 16);
    // len 0 behaves as one classic beat, low address bits cleared, bte ignored
    run_cmd(32'h203, 1'b1, 0, 2'b10, 0, -1, 0, -1, 1'b0, 1);
    // two retries on beat 2 recover; four retries abort
    run_cmd(32'h300, 1'b0, 4, 2'b00, 0, 1, 2, -1, 1'b0, 4);
    run_cmd(32'h300, 1'b0, 4, 2'b00, 0, 1, 3, -1, 1'b0, 4);
    run_cmd(32'h340, 1'b1, 4, 2'b00, 0, 1, 4, -1, 1'b1, 1);
    // bus error on beat 3 of 16
    run_cmd(32'h400, 1'b1, 16, 2'b00, 0, -1, 0, 2, 1'b1, 2);

`ifdef WB_B3_MASTER_TIMEOUT_EN
    // silent slave: strobe held 255 cycles, then abort with error
    cfg_wait = 100000; wait_cnt = 0; d0 = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_adr_i = 32'h500; cmd_we_i = 1'b0; cmd_len_i = 5'd2;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    t = 0;
    #3;
    while (wbm_cyc_o && t < 1000) begin t++; @(negedge clk); #3; end
    check_eq("tmo_cycles", 32'(t), 32'd255);
    @(negedge clk); #3;
    check_eq("tmo_done", 32'(done_cnt - d0), 32'd1);
    check_eq("tmo_err", 32'(last_err), 32'd1);
    cfg_wait = 0; wait_cnt = 0;
`endif

    // reset mid-burst drops the bus at once and produces no completion
    cfg_wait = 100000; wait_cnt = 0; d0 = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_adr_i = 32'h600; cmd_we_i = 1'b1; cmd_len_i = 5'd8;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #1 check_eq("mid_cyc_high", 32'(wbm_cyc_o), 32'd1);
    #1 rst = 1'b1;
    #1 check_eq("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
    check_eq("rst_mid_stb", 32'(wbm_stb_o), 32'd0);
    @(negedge clk); rst = 1'b0; cfg_wait = 0; wait_cnt = 0;
    #3 check_eq("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
    repeat (3) @(negedge clk);
    #3 check_eq("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);

    // normal operation after reset
    run_cmd(32'h700, 1'b0, 2, 2'b00, 0, -1, 0, -1, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
